de1_cl_input_scanner: RTL and testbench

//   Parametrised scanner for the DE1 CL daughterboard inputs. Drives the parallel-in/serial-out

---
 rtl/de1_cl_input_pkg.sv | 22 ++
 rtl/de1_cl_rotary_decoder.sv | 55 +++++
 rtl/de1_cl_input_scanner.sv | 167 ++++++++++++++++
 tb/tb_de1_cl_input_scanner.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/de1_cl_input_pkg.sv
// Shared types and helpers for the DE1 CL input scanner and its rotary decoders.
package de1_cl_input_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } t_scan_fsm;

  typedef struct packed {
    logic direction_pin;
    logic transition_pin;
  } t_rotary_status;

  localparam int NUM_BITS_DEF = 16;

  // Index/counter width that stays legal (>=1 bit) for a range of size n.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/de1_cl_rotary_decoder.sv
// One rotary encoder channel: 2-flop synchroniser, rising-edge detect on the
// transition pin, wrapping up/down position counter and a 1-clk event pulse.
module de1_cl_rotary_decoder
  import de1_cl_input_pkg::*;
#(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   direction_pin,
  input  logic                   transition_pin,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   event_pulse
);

  t_rotary_status         sync1_q, sync1_d;
  t_rotary_status         sync2_q, sync2_d;
  logic                   trans_prev_q, trans_prev_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   event_q, event_d;
  logic                   rise;

  always_comb begin
    sync1_d.direction_pin  = direction_pin;
    sync1_d.transition_pin = transition_pin;
    sync2_d                = sync1_q;
    trans_prev_d           = sync2_q.transition_pin;
    rise                   = sync2_q.transition_pin & ~trans_prev_q;
    count_d                = count_q;
    event_d                = rise;
    if (rise) begin
      count_d = sync2_q.direction_pin ? (count_q + 1'b1) : (count_q - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      trans_prev_q <= 1'b0;
      count_q      <= '0;
      event_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      trans_prev_q <= trans_prev_d;
      count_q      <= count_d;
      event_q      <= event_d;
    end
  end

  assign count       = count_q;
  assign event_pulse = event_q;

endmodule

// File: rtl/de1_cl_input_scanner.sv
// DE1 CL input scanner: drives the PISO shift chain, captures NUM_BITS per scan and
// decodes NUM_ROTARY encoders. Define DE1_CL_INPUT_DEBOUNCE_EN for 3-scan debounce.
//
//   state | meaning
//   IDLE  | gap between scans, sr_shift=1, sr_clock=0, SCAN_GAP ticks
//   LOAD  | parallel load, sr_shift=0 for one tick
//   SHIFT | clock out NUM_BITS bits, one low and one high tick per bit
module de1_cl_input_scanner
  import de1_cl_input_pkg::*;
#(
  parameter int NUM_BITS    = NUM_BITS_DEF,
  parameter int NUM_ROTARY  = 2,
  parameter int CLK_DIV     = 25,
  parameter int SCAN_GAP    = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              inputs_status__sr_data,
  input  logic [NUM_ROTARY-1:0]             rotary_direction_pin,
  input  logic [NUM_ROTARY-1:0]             rotary_transition_pin,
  output logic                              inputs_control__sr_clock,
  output logic                              inputs_control__sr_shift,
  output logic [NUM_BITS-1:0]               sr_bits,
  output logic                              sr_valid,
  output logic [NUM_ROTARY*COUNT_WIDTH-1:0] rotary_count,
  output logic [NUM_ROTARY-1:0]             rotary_event
);

  localparam int IDX_W = idx_width(NUM_BITS);
  localparam int DIV_W = idx_width(CLK_DIV);
  localparam int GAP_W = idx_width(SCAN_GAP);

  logic [DIV_W-1:0]    div_q, div_d;
  logic                tick;
  t_scan_fsm           state_q, state_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    sh_idx;
  logic                phase_q, phase_d;
  logic [NUM_BITS-1:0] shadow_q, shadow_d;
  logic [NUM_BITS-1:0] sr_bits_q, sr_bits_d;
  logic                sr_valid_q, sr_valid_d;
  logic                sr_clock_q, sr_clock_d;
  logic                sr_shift_q, sr_shift_d;
`ifdef DE1_CL_INPUT_DEBOUNCE_EN
  logic [NUM_BITS-1:0] hist1_q, hist1_d;
  logic [NUM_BITS-1:0] hist2_q, hist2_d;
  logic [NUM_BITS-1:0] stable;
`endif

  assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
  assign sh_idx = IDX_W'(NUM_BITS - 1) - idx_q;

  always_comb begin
    div_d      = tick ? '0 : (div_q + 1'b1);
    state_d    = state_q;
    gap_d      = gap_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    shadow_d   = shadow_q;
    sr_bits_d  = sr_bits_q;
    sr_valid_d = 1'b0;
`ifdef DE1_CL_INPUT_DEBOUNCE_EN
    hist1_d    = hist1_q;
    hist2_d    = hist2_q;
    stable     = ~(shadow_q ^ hist1_q) & ~(shadow_q ^ hist2_q);
`endif
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (gap_q == '0) begin
            state_d = LOAD;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
        LOAD: begin
          state_d = SHIFT;
          idx_d   = '0;
          phase_d = 1'b0;
        end
        SHIFT: begin
          if (!phase_q) begin
            phase_d          = 1'b1;
            shadow_d[sh_idx] = inputs_status__sr_data;
          end else if (idx_q == IDX_W'(NUM_BITS - 1)) begin
            // Last bit was captured on the preceding low->high tick.
            state_d    = IDLE;
            gap_d      = GAP_W'(SCAN_GAP - 1);
            sr_valid_d = 1'b1;
`ifdef DE1_CL_INPUT_DEBOUNCE_EN
            sr_bits_d  = (sr_bits_q & ~stable) | (shadow_q & stable);
            hist1_d    = shadow_q;
            hist2_d    = hist1_q;
`else
            sr_bits_d  = shadow_q;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            phase_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    sr_shift_d = (state_d != LOAD);
    sr_clock_d = (state_d == SHIFT) && phase_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      state_q    <= IDLE;
      gap_q      <= GAP_W'(SCAN_GAP - 1);
      idx_q      <= '0;
      phase_q    <= 1'b0;
      shadow_q   <= '0;
      sr_bits_q  <= '0;
      sr_valid_q <= 1'b0;
      sr_clock_q <= 1'b0;
      sr_shift_q <= 1'b1;
    end else begin
      div_q      <= div_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      shadow_q   <= shadow_d;
      sr_bits_q  <= sr_bits_d;
      sr_valid_q <= sr_valid_d;
      sr_clock_q <= sr_clock_d;
      sr_shift_q <= sr_shift_d;
    end
  end

`ifdef DE1_CL_INPUT_DEBOUNCE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist1_q <= '0;
      hist2_q <= '0;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
    end
  end
`endif

  assign inputs_control__sr_clock = sr_clock_q;
  assign inputs_control__sr_shift = sr_shift_q;
  assign sr_bits                  = sr_bits_q;
  assign sr_valid                 = sr_valid_q;

  for (genvar g = 0; g < NUM_ROTARY; g++) begin : g_rot
    de1_cl_rotary_decoder #(
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_dec (
      .clk           (clk),
      .reset_n       (reset_n),
      .direction_pin (rotary_direction_pin[g]),
      .transition_pin(rotary_transition_pin[g]),
      .count         (rotary_count[g*COUNT_WIDTH +: COUNT_WIDTH]),
      .event_pulse   (rotary_event[g])
    );
  end

endmodule

// File: tb/tb_de1_cl_input_scanner.sv
// Bench for de1_cl_input_scanner: shift-chain model, timing/value reference model and
// rotary latency model, checked every cycle, plus fixed literal checkpoints.
module tb_de1_cl_input_scanner;

  localparam int NB     = 8;
  localparam int NR     = 2;
  localparam int DIV    = 4;
  localparam int GAP    = 2;
  localparam int CW     = 8;
  localparam int TICKS  = GAP + 1 + 2 * NB;
  localparam int PERIOD = TICKS * DIV;

`ifdef DE1_CL_INPUT_DEBOUNCE_EN
  localparam logic [7:0] E_SCAN1 = 8'h00;
  localparam logic [7:0] E_SCAN2 = 8'h00;
  localparam logic [7:0] E_SCAN3 = 8'h24;
  localparam logic [7:0] E_SCAN4 = 8'h3C;
  localparam logic [7:0] E_RST1  = 8'h00;
`else
  localparam logic [7:0] E_SCAN1 = 8'hA5;
  localparam logic [7:0] E_SCAN2 = 8'h3C;
  localparam logic [7:0] E_SCAN3 = 8'h3C;
  localparam logic [7:0] E_SCAN4 = 8'h3C;
  localparam logic [7:0] E_RST1  = 8'h3C;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           sr_data;
  logic [NR-1:0]  dir_pin = '0;
  logic [NR-1:0]  trans_pin = '0;
  logic           sr_clock, sr_shift;
  logic [NB-1:0]  sr_bits;
  logic           sr_valid;
  logic [NR*CW-1:0] rotary_count;
  logic [NR-1:0]  rotary_event;

  int n_tests = 0;
  int n_fail  = 0;

  de1_cl_input_scanner #(
    .NUM_BITS(NB), .NUM_ROTARY(NR), .CLK_DIV(DIV), .SCAN_GAP(GAP), .COUNT_WIDTH(CW)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .inputs_status__sr_data  (sr_data),
    .rotary_direction_pin    (dir_pin),
    .rotary_transition_pin   (trans_pin),
    .inputs_control__sr_clock(sr_clock),
    .inputs_control__sr_shift(sr_shift),
    .sr_bits                 (sr_bits),
    .sr_valid                (sr_valid),
    .rotary_count            (rotary_count),
    .rotary_event            (rotary_event)
  );

  always #5 clk = ~clk;

  // External 8-bit parallel-in/serial-out register, MSB presented on sr_data.
  logic [7:0] model_value = 8'hA5;
  logic [7:0] sreg = 8'h00;
  logic       prev_srclk = 1'b0;
  assign sr_data = sreg[7];

  always @(negedge clk) begin
    prev_srclk <= sr_clock;
    if (!sr_shift) sreg <= model_value;
    else if (sr_clock && !prev_srclk) sreg <= {sreg[6:0], 1'b0};
  end

  // Edge counter since reset release; rotary rises scheduled to land 3 clk after the pin change.
  int   t;
  int   stamp [8][NR];
  logic stamp_dir [8][NR];
  logic [NR-1:0] prev_tr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t       <= 0;
      prev_tr <= '0;
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < NR; c++) stamp[i][c] <= -1;
    end else begin
      t       <= t + 1;
      prev_tr <= trans_pin;
      for (int c = 0; c < NR; c++) begin
        if (trans_pin[c] && !prev_tr[c]) begin
          stamp[(t + 3) % 8][c]     <= t + 3;
          stamp_dir[(t + 3) % 8][c] <= dir_pin[c];
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // Reference model, checked every cycle while out of reset.
  initial begin : model
    int k, s;
    logic exp_shift, exp_clk, exp_valid;
    logic [7:0] exp_bits, load_val, h_new, h_old;
    logic [7:0] cnt [NR];
    logic [NR-1:0] exp_evt;
    logic [7:0] caps [$];
    exp_bits = '0; load_val = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_bits = '0;
        load_val = '0;
        for (int c = 0; c < NR; c++) cnt[c] = '0;
        caps = {8'h00, 8'h00};
      end else begin
        k = t / DIV;
        s = k % TICKS;
        exp_shift = (s != GAP);
        exp_clk   = (s > GAP) ? (((s - GAP - 1) % 2) == 1) : 1'b0;
        exp_valid = (t > 0) && ((t % PERIOD) == 0);
        if (s == GAP) load_val = model_value;
        if (exp_valid) begin
`ifdef DE1_CL_INPUT_DEBOUNCE_EN
          h_new = caps[caps.size() - 1];
          h_old = caps[caps.size() - 2];
          for (int b = 0; b < 8; b++)
            if (load_val[b] == h_new[b] && load_val[b] == h_old[b]) exp_bits[b] = load_val[b];
          caps.push_back(load_val);
          void'(caps.pop_front());
`else
          exp_bits = load_val;
`endif
        end
        exp_evt = '0;
        for (int c = 0; c < NR; c++) begin
          if (stamp[t % 8][c] == t) begin
            exp_evt[c] = 1'b1;
            cnt[c] = stamp_dir[t % 8][c] ? cnt[c] + 8'd1 : cnt[c] - 8'd1;
          end
        end
        check("sr_shift", 64'(sr_shift), 64'(exp_shift));
        check("sr_clock", 64'(sr_clock), 64'(exp_clk));
        check("sr_valid", 64'(sr_valid), 64'(exp_valid));
        check("sr_bits", 64'(sr_bits), 64'(exp_bits));
        check("rotary_count", 64'(rotary_count), 64'({cnt[1], cnt[0]}));
        check("rotary_event", 64'(rotary_event), 64'(exp_evt));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_t(input int target);
    int guard = 0;
    while (t < target && guard < 20000) begin
      step(1);
      guard++;
    end
    check("wait_t", 64'(t), 64'(target));
  endtask

  task automatic pulse(input logic [NR-1:0] mask, input logic [NR-1:0] dir,
                       input logic [7:0] exp0, input logic [7:0] exp1);
    dir_pin = dir;
    step(2);
    trans_pin = mask;
    step(3);
    check("pulse_cnt0", 64'(rotary_count[7:0]), 64'(exp0));
    check("pulse_cnt1", 64'(rotary_count[15:8]), 64'(exp1));
    check("pulse_evt", 64'(rotary_event), 64'(mask));
    trans_pin = '0;
    step(2);
  endtask

  initial begin : driver
    int hold [NR];
    step(4);
    reset_n = 1'b1;

    // Channel 0: three up, five down.
    pulse(2'b01, 2'b01, 8'h01, 8'h00);
    pulse(2'b01, 2'b01, 8'h02, 8'h00);
    pulse(2'b01, 2'b01, 8'h03, 8'h00);
    pulse(2'b01, 2'b00, 8'h02, 8'h00);
    pulse(2'b01, 2'b00, 8'h01, 8'h00);
    pulse(2'b01, 2'b00, 8'h00, 8'h00);
    pulse(2'b01, 2'b00, 8'hFF, 8'h00);
    pulse(2'b01, 2'b00, 8'hFE, 8'h00);

    wait_t(76);
    check("scan1_valid", 64'(sr_valid), 64'd1);
    check("scan1_bits", 64'(sr_bits), 64'(E_SCAN1));
    step(2);
    model_value = 8'h3C;
    wait_t(152);
    check("scan2_valid", 64'(sr_valid), 64'd1);
    check("scan2_bits", 64'(sr_bits), 64'(E_SCAN2));
    wait_t(228);
    check("scan3_bits", 64'(sr_bits), 64'(E_SCAN3));
    wait_t(304);
    check("scan4_bits", 64'(sr_bits), 64'(E_SCAN4));

    // Reset in SHIFT, bit 4 low phase.
    wait_t(4 * PERIOD + (GAP + 1 + 8) * DIV + 1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_sr_clock", 64'(sr_clock), 64'd0);
    check("rst_sr_shift", 64'(sr_shift), 64'd1);
    check("rst_sr_bits", 64'(sr_bits), 64'd0);
    check("rst_sr_valid", 64'(sr_valid), 64'd0);
    check("rst_count", 64'(rotary_count), 64'd0);
    check("rst_event", 64'(rotary_event), 64'd0);
    step(3);
    reset_n = 1'b1;

    // Simultaneous channels, then wrap at 0xFF on channel 0.
    pulse(2'b11, 2'b01, 8'h01, 8'hFF);
    pulse(2'b01, 2'b00, 8'h00, 8'hFF);
    pulse(2'b01, 2'b00, 8'hFF, 8'hFF);
    pulse(2'b01, 2'b01, 8'h00, 8'hFF);

    wait_t(75);
    check("post_rst_bits", 64'(sr_bits), 64'd0);
    check("post_rst_valid", 64'(sr_valid), 64'd0);
    wait_t(76);
    check("post_rst_scan", 64'(sr_bits), 64'(E_RST1));

    hold[0] = 2;
    hold[1] = 3;
    repeat (1600) begin
      step(1);
      for (int c = 0; c < NR; c++) begin
        if (hold[c] == 0) begin
          trans_pin[c] = ~trans_pin[c];
          if (!trans_pin[c]) dir_pin[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 4);
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 39) == 0) model_value = 8'($urandom);
    end
    step(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
